// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the SAP datapath: widths, control-bit positions,
// the control-word struct, opcodes and a small helper.
package cpu_datapath_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CTRL_W = 15;
  localparam int unsigned OPC_W  = 4;

  // Control-word bit positions, shared with cpu_control
  localparam int unsigned BIT_EP = 0;
  localparam int unsigned BIT_LM = 1;
  localparam int unsigned BIT_C  = 2;
  localparam int unsigned BIT_LI = 3;
  localparam int unsigned BIT_EM = 4;
  localparam int unsigned BIT_LA = 5;
  localparam int unsigned BIT_LB = 6;
  localparam int unsigned BIT_LC = 7;
  localparam int unsigned BIT_LD = 8;
  localparam int unsigned BIT_EA = 9;
  localparam int unsigned BIT_EB = 10;
  localparam int unsigned BIT_ES = 11;
  localparam int unsigned BIT_LO = 12;
  localparam int unsigned BIT_EI = 13;
  localparam int unsigned BIT_LP = 14;

  // Single-bit masks for composing control words
  localparam logic [CTRL_W-1:0] CTRL_EP = CTRL_W'(1) << BIT_EP;
  localparam logic [CTRL_W-1:0] CTRL_LM = CTRL_W'(1) << BIT_LM;
  localparam logic [CTRL_W-1:0] CTRL_C  = CTRL_W'(1) << BIT_C;
  localparam logic [CTRL_W-1:0] CTRL_LI = CTRL_W'(1) << BIT_LI;
  localparam logic [CTRL_W-1:0] CTRL_EM = CTRL_W'(1) << BIT_EM;
  localparam logic [CTRL_W-1:0] CTRL_LA = CTRL_W'(1) << BIT_LA;
  localparam logic [CTRL_W-1:0] CTRL_LB = CTRL_W'(1) << BIT_LB;
  localparam logic [CTRL_W-1:0] CTRL_LC = CTRL_W'(1) << BIT_LC;
  localparam logic [CTRL_W-1:0] CTRL_LD = CTRL_W'(1) << BIT_LD;
  localparam logic [CTRL_W-1:0] CTRL_EA = CTRL_W'(1) << BIT_EA;
  localparam logic [CTRL_W-1:0] CTRL_EB = CTRL_W'(1) << BIT_EB;
  localparam logic [CTRL_W-1:0] CTRL_ES = CTRL_W'(1) << BIT_ES;
  localparam logic [CTRL_W-1:0] CTRL_LO = CTRL_W'(1) << BIT_LO;
  localparam logic [CTRL_W-1:0] CTRL_EI = CTRL_W'(1) << BIT_EI;
  localparam logic [CTRL_W-1:0] CTRL_LP = CTRL_W'(1) << BIT_LP;

  // Control word as a struct; member order matches the bit positions (ep = bit 0)
  typedef struct packed {
    logic lp;
    logic ei;
    logic lo;
    logic es;
    logic eb;
    logic ea;
    logic ld;
    logic lc;
    logic lb;
    logic la;
    logic em;
    logic li;
    logic c;
    logic lm;
    logic ep;
  } ctrl_t;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // True when two or more bits of v are set
  function automatic logic multi_hot6(input logic [5:0] v);
    return (v & (v - 6'd1)) != 6'd0;
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Control/memory/status bundle between cpu_control (master) and cpu_datapath (slave).
//   control_lines : control word into the datapath
//   mem_addr/mem_rdata : program-memory address out, combinational read data in
//   bus_out, reg_ir, flag_lines, out_reg, bus_conflict : status back to control/system
interface cpu_datapath_if
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AW    = ADDR_W
);
  logic [CTRL_W-1:0] control_lines;
  logic [AW-1:0]     mem_addr;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  bus_out;
  logic [OPC_W-1:0]  reg_ir;
  logic [1:0]        flag_lines;
  logic [WIDTH-1:0]  out_reg;
  logic              bus_conflict;

  modport master (
    output control_lines, mem_rdata,
    input  mem_addr, bus_out, reg_ir, flag_lines, out_reg, bus_conflict
  );

  modport slave (
    input  control_lines, mem_rdata,
    output mem_addr, bus_out, reg_ir, flag_lines, out_reg, bus_conflict
  );
endinterface

// File: rtl/cpu_datapath_reg.sv
// Generic datapath register: load enable, async active-low clear, optional +1.
//   clk, rst : clock and async active-low clear
//   ld, d    : load d on the rising edge (load beats increment)
//   inc      : increment when INC is set and ld is low
//   q        : register contents
module cpu_datapath_reg #(
  parameter int unsigned W   = 8,
  parameter bit          INC = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (INC && inc) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// SAP register/bus datapath: PC, MAR, IR, A-D, adder, flags and output register
// around one shared bus.
//   clk, rst : clock, async active-low reset
//   dp       : control word and memory data in; memory address, bus value,
//              opcode, flags, output register and bus-conflict status out
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AW    = ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  cpu_datapath_if.slave  dp
);

  ctrl_t            cw;
  logic [WIDTH-1:0] bus;
  logic [WIDTH:0]   sum;
  logic [5:0]       drv;

  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    mar_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             zero_q;
  logic             unused_cd;

  assign cw  = ctrl_t'(dp.control_lines);
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // Bus mux, fixed priority EP > EM > EI > ES > EA > EB
  always_comb begin
    bus = '0;
    if (cw.ep) begin
      bus = WIDTH'(pc_q);
    end else if (cw.em) begin
      bus = dp.mem_rdata;
    end else if (cw.ei) begin
      bus = WIDTH'(ir_q[AW-1:0]);
    end else if (cw.es) begin
      bus = sum[WIDTH-1:0];
    end else if (cw.ea) begin
      bus = a_q;
    end else if (cw.eb) begin
      bus = b_q;
    end
  end

  assign drv = {cw.ep, cw.em, cw.ei, cw.es, cw.ea, cw.eb};

  // PC: LP load takes precedence over C increment
  cpu_datapath_reg #(.W(AW), .INC(1'b1)) u_pc (
    .clk(clk), .rst(rst), .ld(cw.lp), .inc(cw.c), .d(bus[AW-1:0]), .q(pc_q)
  );

  cpu_datapath_reg #(.W(AW)) u_mar (
    .clk(clk), .rst(rst), .ld(cw.lm), .inc(1'b0), .d(bus[AW-1:0]), .q(mar_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_ir (
    .clk(clk), .rst(rst), .ld(cw.li), .inc(1'b0), .d(bus), .q(ir_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_a (
    .clk(clk), .rst(rst), .ld(cw.la), .inc(1'b0), .d(bus), .q(a_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_b (
    .clk(clk), .rst(rst), .ld(cw.lb), .inc(1'b0), .d(bus), .q(b_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_c (
    .clk(clk), .rst(rst), .ld(cw.lc), .inc(1'b0), .d(bus), .q(c_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_d (
    .clk(clk), .rst(rst), .ld(cw.ld), .inc(1'b0), .d(bus), .q(d_q)
  );

  cpu_datapath_reg #(.W(WIDTH)) u_out (
    .clk(clk), .rst(rst), .ld(cw.lo), .inc(1'b0), .d(bus), .q(out_q)
  );

  // C and D have no bus driver in this machine; they are architectural state only
  assign unused_cd = ^{c_q, d_q};

  // Flags capture the adder result only on an ES edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (cw.es) begin
      carry_q <= sum[WIDTH];
      zero_q  <= (sum[WIDTH-1:0] == '0);
    end
  end

  assign dp.mem_addr     = mar_q;
  assign dp.bus_out      = bus;
  assign dp.bus_conflict = multi_hot6(drv);
  assign dp.reg_ir       = ir_q[WIDTH-1:WIDTH-OPC_W];
  assign dp.flag_lines   = {zero_q, carry_q};
  assign dp.out_reg      = out_q;

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Register/bus datapath of the 4-bit SAP computer, directly downstream of `cpu_control`. It consumes the registered 15-bit `control_lines` word and owns the shared 8-bit bus. It holds PC, MAR, IR, general registers A/B/C/D, the adder, the flag register and the output register. It returns the opcode nibble, the bus value and the flags to the control unit, and drives the program-memory address.

## Interface
- `WIDTH`, 8: data/bus width.
- `AW`, 4: address width (PC, MAR, IR operand nibble).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `control_lines` input 15: one-hot-per-function control word from `cpu_control`.
- `mem_addr` output AW: current MAR contents, to program memory.
- `mem_rdata` input WIDTH: combinational read data from program memory.
- `bus_out` output WIDTH: current bus value; feeds `cpu_control.bus_in`.
- `reg_ir` output 4: IR[7:4], the opcode.
- `flag_lines` output 2: [0] carry, [1] zero.
- `out_reg` output WIDTH: output register.
- `bus_conflict` output 1: more than one bus driver enabled this cycle (combinational).

## Operation
- Control bit positions are fixed, defined in `defines.v`: EP=0, LM=1, C=2, LI=3, EM=4, LA=5, LB=6, LC=7, LD=8, EA=9, EB=10, ES=11, LO=12, EI=13, LP=14.
- Bus drivers:
  - EP: {0, PC}.
  - EM: `mem_rdata`.
  - EI: {0, IR[3:0]}.
  - ES: sum[7:0].
  - EA: A.
  - EB: B.
- Fixed bus priority when several drivers are enabled: EP > EM > EI > ES > EA > EB. No enable drives bus = 0.
- `bus_conflict` = 1 when two or more of the six driver bits are set. The priority winner still drives the bus.
- Loads, on the rising edge when the bit is set:
  - LM: MAR <= bus[3:0].
  - LI: IR <= bus.
  - LA/LB/LC/LD: A/B/C/D <= bus.
  - LO: out_reg <= bus.
  - LP: PC <= bus[3:0].
- Several load bits may be set together; every selected register loads the same bus value. A register that both drives and loads (e.g. EA|LA) reloads its own value.
- PC:
  - C increments PC mod 16 (15 -> 0).
  - LP and C together: LP wins, and PC = bus[3:0].
- Adder: sum = {0,A} + {0,B}, 9 bits.
- Flags update only on an edge where ES is set: carry <= sum[8], zero <= (sum[7:0] == 0). Otherwise the flags hold.
- Unsupported bits and control words with no bits set cause no state change.

## Timing
- Reset (rst low, asynchronous): PC, MAR, IR, A, B, C, D, out_reg and flags all clear to 0 immediately, regardless of clk. Outputs are therefore `mem_addr`=0, `reg_ir`=0, `flag_lines`=0, `out_reg`=0.
- After reset deasserts, the first rising edge is a normal edge.
- Bus, `bus_out`, `bus_conflict` and `sum` are combinational from the registers, `control_lines` and `mem_rdata`. They have zero latency.
- Register loads take effect one edge after `control_lines` presents the load bit.
- Fetch sequence seen by the datapath:
  - Edge 1: MAR <= PC (EP|LM).
  - Edge 2: IR <= mem[MAR], PC+1 (C|LI|EM).
  - Edge 3: execute word.
- `reg_ir` is valid from the edge following LI.
- Reset mid-instruction discards all partial results; no flag or register retains a pre-reset value.

## Structure
- `defines.v` (shared): control bit position macros (`EP`..`LP` as masks), opcode macros, `WIDTH`/`AW` defaults. Both `cpu_control` and `cpu_datapath` include it.
- One natural sub-module, `cpu_reg`: a WIDTH-parameterised register with load enable, async active-low clear and optional increment. It is instantiated for PC (AW, increment), MAR, IR, A–D and OUT.
- Bus mux, adder and flag logic stay inline in `cpu_datapath`.

## Test plan
- Reset: set arbitrary register state, pulse rst low between edges -> all outputs 0 at once, `mem_addr`=0, `flag_lines`=2'b00.
- Fetch: mem[0]=8'h1A, apply EP|LM then C|LI|EM -> `mem_addr`=0, IR=8'h1A, `reg_ir`=4'h1, PC=1.
- Load and add with carry:
  - EI with IR=8'h0F, then LA -> A=8'h0F.
  - Force B=8'hF1 via bus, then ES|LA -> A=8'h00, `flag_lines`=2'b11.
  - A following word without ES -> flags held.
- Jump precedence: PC=5, IR low nibble=9, EI|LP|C -> PC=9. PC=15 with C only -> PC=0.
- Bus conflict: EA|EB with A=8'h33, B=8'h44 -> `bus_out`=8'h33, `bus_conflict`=1. Empty control word -> `bus_out`=0, `bus_conflict`=0.
- Output and multi-load: A=8'h5C, EA|LO|LC|LD -> `out_reg`=C=D=8'h5C, A unchanged.
